// File: rtl/sseg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_driver_if
// Description : Load handshake between a value producer and the
//               seven-segment scan driver.
//               data  : 14-bit binary value to display (0..9999 is legal)
//               valid : one-cycle load strobe, honoured only while busy = 0
//               busy  : binary-to-BCD conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface sseg_scan_driver_if;
    logic [13:0] data;
    logic        valid;
    logic        busy;

    // Producer side: drives the value and strobe, watches busy.
    modport master (
        output data,
        output valid,
        input  busy
    );

    // Driver side: consumes the value and strobe, reports busy.
    modport slave (
        input  data,
        input  valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_driver
// Description : Four-digit seven-segment driver for the Basys3 display.
//               A slow divided clock (sclk), sampled as data in the clk
//               domain, paces the digit scan. A 14-bit binary value loaded
//               through a valid/busy handshake is converted to BCD by a
//               sequential double-dabble engine (14 shift cycles + 1 load
//               cycle). Values above 9999 show dashes on all digits.
// Ports       : clk  - system clock, the only clock
//               rst  - synchronous active-high reset
//               sclk - divided clock; each rising edge advances the scan
//               bus  - load handshake (data / valid / busy), slave side
//               an   - digit anodes, active-low, an[0] = rightmost digit
//               seg  - cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a
// Parameters  : BLANK_LZ - 1 blanks leading-zero digits (digit 0 always lit)
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              sclk,
    sseg_scan_driver_if.slave      bus,
    output logic [3:0]             an,
    output logic [6:0]             seg
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0]  C_LAST_ITER = 4'd13;      // 14 shift cycles: 0..13
    localparam logic [13:0] C_MAX_VALUE = 14'd9999;
    localparam logic [6:0]  C_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  C_SEG_DASH  = 7'b0111111;

    // ------------------------------------------------------------------------
    // Conversion FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q,    state_d;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic        sclk_q,     sclk_d;
    logic [1:0]  idx_q,      idx_d;
    logic [13:0] bin_q,      bin_d;       // binary shift register
    logic [15:0] bcd_q,      bcd_d;       // BCD accumulator, 4 nibbles
    logic [3:0]  iter_q,     iter_d;      // shift iteration counter
    logic        ovf_pend_q, ovf_pend_d;  // out-of-range flag of captured value
    logic [15:0] disp_q,     disp_d;      // displayed BCD digits
    logic        ovf_q,      ovf_d;       // displayed value is out of range

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        rise;
    logic [15:0] bcd_adj;                 // accumulator after the +3 correction
    logic [3:0]  cur_digit;
    logic        cur_blank;

    // Rising edge of the divided clock, seen as a one-cycle pulse.
    assign rise = sclk & ~sclk_q;

    // Double-dabble correction: any nibble of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    // A nibble never exceeds 9 before correction, so no carry leaves a nibble.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_bcd_adj
            assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5)
                                       ? (bcd_q[4*g +: 4] + 4'd3)
                                       : bcd_q[4*g +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // sclk is tracked through reset so the first cycle afterwards cannot
        // see a false rising edge when sclk is already high.
        sclk_q <= sclk_d;
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            iter_q     <= 4'd0;
            ovf_pend_q <= 1'b0;
            disp_q     <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Scan index: one step per sclk rising edge, wraps naturally at 2 bits.
    // ------------------------------------------------------------------------
    always_comb begin
        sclk_d = sclk;
        idx_d  = idx_q;
        if (rise) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Conversion FSM: next state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        bus.busy   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    bin_d      = bus.data;
                    bcd_d      = 16'd0;
                    iter_d     = 4'd0;
                    // The range decision is taken at capture time because the
                    // binary register is consumed by the shifting.
                    ovf_pend_d = (bus.data > C_MAX_VALUE);
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                bus.busy = 1'b1;
                // {BCD, bin} shifted left by one after correction.
                bcd_d    = {bcd_adj[14:0], bin_q[13]};
                bin_d    = {bin_q[12:0], 1'b0};
                if (iter_q == C_LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + 4'd1;
                end
            end

            S_DONE: begin
                bus.busy = 1'b1;
                disp_d   = bcd_q;
                ovf_d    = ovf_pend_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Digit selection and leading-zero detection for the active digit.
    // A digit k >= 1 is a leading zero when it and every higher digit are 0.
    // ------------------------------------------------------------------------
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        case (idx_q)
            2'd0: begin
                cur_digit = disp_q[3:0];
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = disp_q[7:4];
                cur_blank = (disp_q[15:4] == 12'd0);
            end
            2'd2: begin
                cur_digit = disp_q[11:8];
                cur_blank = (disp_q[15:8] == 8'd0);
            end
            default: begin
                cur_digit = disp_q[15:12];
                cur_blank = (disp_q[15:12] == 4'd0);
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded purely from registered state.
    // ------------------------------------------------------------------------
    assign an = ~(4'b0001 << idx_q);

    always_comb begin
        seg = C_SEG_BLANK;
        if (ovf_q) begin
            seg = C_SEG_DASH;
        end else if (BLANK_LZ && cur_blank) begin
            seg = C_SEG_BLANK;
        end else begin
            case (cur_digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = C_SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_driver
// Description : Directed self-checking bench for sseg_scan_driver. Two
//               instances share clk/rst/sclk: one with leading-zero blanking,
//               one without. Expected segment patterns are hand-written.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_idx = 2'd0;

    sseg_scan_driver_if if0 ();
    sseg_scan_driver_if if1 ();

    sseg_scan_driver #(.BLANK_LZ(1'b1)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .bus  (if0.slave),
        .an   (an0),
        .seg  (seg0)
    );

    sseg_scan_driver #(.BLANK_LZ(1'b0)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .bus  (if1.slave),
        .an   (an1),
        .seg  (seg1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [13:0] d, input logic v);
        if0.data  = d;
        if0.valid = v;
        if1.data  = d;
        if1.valid = v;
    endtask

    // One sclk rising edge, registered into idx at the second tick.
    task automatic rise();
        sclk = 1'b0;
        tick();
        sclk = 1'b1;
        tick();
        exp_idx = exp_idx + 2'd1;
    endtask

    // Load a value, optionally pulse a second valid at busy cycle inject_at,
    // and check that busy stays high exactly 15 cycles.
    task automatic load(input logic [13:0] v, input int inject_at, input logic [13:0] v2);
        int cnt;
        set_in(v, 1'b1);
        tick();
        set_in(14'd0, 1'b0);
        check("busy_rise", {15'd0, if0.busy}, 16'd1);
        cnt = 0;
        while (if0.busy && cnt < 40) begin
            if (cnt + 1 == inject_at) set_in(v2, 1'b1);
            tick();
            set_in(14'd0, 1'b0);
            cnt++;
        end
        check("busy_len", cnt[15:0], 16'd15);
    endtask

    // Walk all four digits with sclk rises and check anode and cathodes on
    // both instances. a*/b* are the digit patterns (3 = leftmost).
    task automatic check_all(input string tag,
                             input logic [6:0] a3, input logic [6:0] a2,
                             input logic [6:0] a1, input logic [6:0] a0,
                             input logic [6:0] b3, input logic [6:0] b2,
                             input logic [6:0] b1, input logic [6:0] b0);
        logic [6:0] ea [4];
        logic [6:0] eb [4];
        logic [3:0] ean;
        logic [3:0] one;
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
        one = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            rise();
            ean = ~(one << exp_idx);
            check({tag, "_an"},   {12'd0, an0},  {12'd0, ean});
            check({tag, "_seg0"}, {9'd0, seg0},  {9'd0, ea[exp_idx]});
            check({tag, "_seg1"}, {9'd0, seg1},  {9'd0, eb[exp_idx]});
        end
    endtask

    initial begin
        logic [3:0] an_hold;
        logic       steady;
        logic [3:0] ean;
        logic [3:0] one;
        one = 4'b0001;
        set_in(14'd0, 1'b0);

        // ---------------- Reset with sclk high ----------------
        rst  = 1'b1;
        sclk = 1'b1;
        repeat (3) tick();
        check("rst_an",   {12'd0, an0},      16'h000e);
        check("rst_seg",  {9'd0, seg0},      {9'd0, S0});
        check("rst_busy", {15'd0, if0.busy}, 16'd0);
        rst = 1'b0;
        tick();
        check("rel_an", {12'd0, an0}, 16'h000e);
        tick();
        check("rel_an2", {12'd0, an0}, 16'h000e);
        exp_idx = 2'd0;

        // ---------------- Full value 1234 ----------------
        load(14'd1234, 0, 14'd0);
        check("new_val_seg", {9'd0, seg0}, {9'd0, S4});
        check_all("v1234", S1, S2, S3, S4, S1, S2, S3, S4);
        check("wrap_an", {12'd0, an0}, 16'h000e);

        // ---------------- Blanking ----------------
        load(14'd7, 0, 14'd0);
        check_all("v7", SB, SB, SB, S7, S0, S0, S0, S7);
        load(14'd0, 0, 14'd0);
        check_all("v0", SB, SB, SB, S0, S0, S0, S0, S0);
        load(14'd1005, 0, 14'd0);
        check_all("v1005", S1, S0, S0, S5, S1, S0, S0, S5);

        // ---------------- Overflow, then recovery ----------------
        load(14'd12000, 0, 14'd0);
        check_all("v12000", SD, SD, SD, SD, SD, SD, SD, SD);
        load(14'd9999, 0, 14'd0);
        check_all("v9999", S9, S9, S9, S9, S9, S9, S9, S9);

        // ---------------- Ignored valid while busy ----------------
        load(14'd4321, 3, 14'd1111);
        check_all("v4321", S4, S3, S2, S1, S4, S3, S2, S1);

        // ---------------- Reset mid-conversion ----------------
        rise();
        set_in(14'd5555, 1'b1);
        tick();
        set_in(14'd0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", {15'd0, if0.busy}, 16'd0);
        check("mrst_an",   {12'd0, an0},      16'h000e);
        check("mrst_seg",  {9'd0, seg0},      {9'd0, S0});
        exp_idx = 2'd0;
        repeat (20) tick();
        check("mrst_busy2", {15'd0, if0.busy}, 16'd0);
        check("mrst_seg2",  {9'd0, seg0},      {9'd0, S0});

        // ---------------- Scan pacing ----------------
        sclk    = 1'b1;
        an_hold = an0;
        steady  = 1'b1;
        repeat (100) begin
            tick();
            if (an0 !== an_hold) steady = 1'b0;
        end
        check("hold_an_steady", {15'd0, steady}, 16'd1);
        check("hold_an_value",  {12'd0, an0},    16'h000e);
        for (int i = 0; i < 5; i++) begin
            rise();
            ean = ~(one << exp_idx);
            check("pace_an", {12'd0, an0}, {12'd0, ean});
        end
        check("pace_final_an", {12'd0, an0}, 16'h000d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Four-digit seven-segment display driver for the Basys3 display, placed directly downstream of the generic clock divider. It takes the divider's slow square wave `sclk` as an ordinary data input in the `clk` domain and advances the digit scan on each rising edge. It also accepts a 14-bit binary value through a valid/busy handshake and converts it to BCD with a sequential double-dabble engine. The block drives the active-low anode and cathode pins directly.

## Interface

- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked; digit 0 is always shown.
- `clk  in  1`: system clock (100 MHz); the only clock.
- `rst  in  1`: reset, synchronous and active-high.
- `sclk  in  1`: divided clock from the clock divider, sampled in the `clk` domain; its rising edges pace the scan.
- `data  in  14`: binary value to display; legal range 0..9999.
- `valid  in  1`: load strobe for `data`, honoured only when `busy`=0.
- `busy  out  1`: conversion in progress.
- `an  out  4`: digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg  out  7`: cathodes, active-low; `seg[6:0]` = g,f,e,d,c,b,a.

## Operation

- **Edge detect:** `sclk_q` registers `sclk` each `clk` cycle. `rise = sclk & ~sclk_q`. While `rst`=1, `sclk_q` loads `sclk`, so no spurious rise occurs on the first cycle after reset.
- **Scan index:** 2-bit `idx`, increments on each `rise` cycle and wraps 3→0. No advance while `sclk` is held at a constant level.
- **Anodes:** `an = ~(4'b0001 << idx)`. Exactly one digit is on at all times.
- **Display register:** four BCD digits plus an `ovf` flag. It is written only in the DONE state.
- **Conversion FSM:**
  - IDLE: on `valid`=1, capture `data` into a 14-bit shift register, clear the 16-bit BCD accumulator and the iteration counter, go to SHIFT.
  - SHIFT: 14 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1. After the 14th cycle go to DONE.
  - DONE: 1 cycle. Load the display register from the BCD accumulator. Set `ovf` = (captured data > 9999). Return to IDLE.
- **Busy and handshake:**
  - `busy`=1 in SHIFT and DONE.
  - `valid` while `busy`=1 is ignored; no queueing.
  - `valid` and `data` need only be held for one cycle.
- **Digit decode:**
  - `ovf`=1: every digit shows a dash, 0111111.
  - Otherwise, with `BLANK_LZ`=1, digit *k* (k≥1) is blank (1111111) if it and all higher digits are 0.
  - Otherwise standard hex-to-7seg active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Reset (any time, including mid-conversion):**
  - FSM → IDLE, `busy`=0, `idx`=0.
  - Display register = 0, `ovf`=0.
  - The partial conversion is discarded.

## Timing

- **Reset values:** `busy`=0, `an`=1110, `seg`=1000000 (digit 0 shows "0").
- **Conversion latency:** `valid` is sampled at edge N. `busy` rises after edge N and stays high for exactly 15 cycles (SHIFT on N+1..N+14, DONE on N+15). `busy` falls after edge N+15.
- **New-value timing:** `an`/`seg` reflect the new value from edge N+15 onward.
- **Back-to-back loads:** the earliest accepted follow-up `valid` is at edge N+16, so one load is accepted per 16 cycles.
- **Scan timing:**
  - `an` changes on the same `clk` edge at which `rise` is registered into `idx`, i.e. one cycle after `sclk` goes high at a sampling edge.
  - Scan period is 4 `sclk` periods.
- **Simultaneous DONE and `rise`:** both apply on the same edge. `seg` shows the new value for the new `idx`.
- **Output glitches:** `an`/`seg` are decoded only from registered state and change only on `clk` edges.

## Test plan

1. **Reset:** assert `rst` for 3 cycles with `sclk`=1 → `an`=1110, `seg`=1000000, `busy`=0. Release with `sclk` still 1 → `an` holds 1110 (no rise).
2. **Full value:** `data`=1234, `valid` for 1 cycle → `busy` high exactly 15 cycles. Then toggle `sclk` and check:
   - 1110 / 0011001 ("4")
   - 1101 / 0110000 ("3")
   - 1011 / 0100100 ("2")
   - 0111 / 1111001 ("1")
   - then wrap to 1110.
3. **Blanking:** `BLANK_LZ`=1, `data`=7 → digit 0 = 1111000, digits 1–3 = 1111111. `data`=0 → digit 0 = 1000000. `data`=1005 → "1","0","0","5" all lit. With `BLANK_LZ`=0 and `data`=7 → digits 1–3 = 1000000.
4. **Overflow:** `data`=12000 → all four digits show 0111111, after the same 15-cycle `busy`. A subsequent `data`=9999 → "9999", `ovf` cleared.
5. **Ignored valid and mid-conversion reset:**
   - `data`=4321 loaded, then `valid` with `data`=1111 at busy cycle 3 → display "4321".
   - New load, then `rst` at busy cycle 5 → `busy`=0 the next cycle, display "0", `idx`=0.
6. **Scan pacing:** hold `sclk` high for 100 cycles → `an` constant. Apply 5 rising edges → `idx` sequence 1,2,3,0,1, one step per edge.
